// File: rtl/matrix_pkg.sv
// Shared constants, state encoding and config helpers for matrix_job_driver.
// Holds multiplier address map, start bit, config field positions.
package matrix_pkg;

  localparam int DATA_W_DEF    = 32;
  localparam int ADDR_W_DEF    = 12;
  localparam int A_BASE_DEF    = 2;
  localparam int B_BASE_DEF    = 1026;
  localparam int R_BASE_DEF    = 2050;
  localparam int MAX_WORDS_DEF = 1024;

  localparam int STATUS_ADDR = 0;
  localparam int CONFIG_ADDR = 1;

  localparam logic [31:0] START_BIT = 32'h8000_0000;

  localparam int IDX_W = 11;
  localparam int ST_W  = 4;
  localparam int DIM_W = 8;

  localparam int CFG_RA_LSB = 24;
  localparam int CFG_CA_LSB = 16;
  localparam int CFG_RB_LSB = 8;
  localparam int CFG_CB_LSB = 0;

  localparam logic [ST_W-1:0] S_IDLE    = 4'd0;
  localparam logic [ST_W-1:0] S_CLR     = 4'd1;
  localparam logic [ST_W-1:0] S_CFG     = 4'd2;
  localparam logic [ST_W-1:0] S_LOAD_A  = 4'd3;
  localparam logic [ST_W-1:0] S_LOAD_B  = 4'd4;
  localparam logic [ST_W-1:0] S_START   = 4'd5;
  localparam logic [ST_W-1:0] S_WAIT    = 4'd6;
  localparam logic [ST_W-1:0] S_RD_ADDR = 4'd7;
  localparam logic [ST_W-1:0] S_RD_DATA = 4'd8;
  localparam logic [ST_W-1:0] S_OUT     = 4'd9;
  localparam logic [ST_W-1:0] S_FIN     = 4'd10;

  function automatic logic [DIM_W-1:0] cfg_dim(
    input logic [31:0] cfg,
    input int          lsb
  );
    return cfg[lsb +: DIM_W];
  endfunction

  function automatic logic [15:0] prod_words(
    input logic [DIM_W-1:0] r,
    input logic [DIM_W-1:0] c
  );
    return 16'(r) * 16'(c);
  endfunction

endpackage

// File: rtl/matrix_job_driver_if.sv
// Bundle of job command, operand stream, multiplier memory port and
// result stream. master = driver side, slave = host/multiplier side.
interface matrix_job_driver_if
  import matrix_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic              cmd_valid;
  logic [31:0]       cmd_config;
  logic              cmd_ready;

  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;

  logic [DATA_W-1:0] memory_data_in;
  logic [ADDR_W-1:0] memory_address;
  logic              write_enable;
  logic [DATA_W-1:0] memory_data_out;
  logic              result_ready;

  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;

  logic              busy;
  logic              error;

  modport master (
    input  cmd_valid, cmd_config,
    output cmd_ready,
    input  in_data, in_valid,
    output in_ready,
    output memory_data_in, memory_address, write_enable,
    input  memory_data_out, result_ready,
    output out_data, out_valid, out_last,
    input  out_ready,
    output busy, error
  );

  modport slave (
    output cmd_valid, cmd_config,
    input  cmd_ready,
    output in_data, in_valid,
    input  in_ready,
    input  memory_data_in, memory_address, write_enable,
    output memory_data_out, result_ready,
    input  out_data, out_valid, out_last,
    output out_ready,
    input  busy, error
  );

endinterface

// File: rtl/matrix_job_driver.sv
// Job sequencer for the matrix_multiplier memory port: clear, config,
// load A/B, start, wait, read back R, clear. Ports: clk, reset, bus.
// Optional result_ready watchdog enabled by defining MM_TIMEOUT_EN.
module matrix_job_driver
  import matrix_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int A_BASE    = A_BASE_DEF,
  parameter int B_BASE    = B_BASE_DEF,
  parameter int R_BASE    = R_BASE_DEF,
  parameter int MAX_WORDS = MAX_WORDS_DEF
`ifdef MM_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 65535
`endif
) (
  input logic                clk,
  input logic                reset,
  matrix_job_driver_if.master bus
);

`ifdef MM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] cnt_q, cnt_d;
`endif

  logic [ST_W-1:0]   state_q, state_d;
  logic [31:0]       cfg_q, cfg_d;
  logic [IDX_W-1:0]  na_q, na_d;
  logic [IDX_W-1:0]  nb_q, nb_d;
  logic [IDX_W-1:0]  nr_q, nr_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] odata_q, odata_d;
  logic              ovalid_q, ovalid_d;
  logic              olast_q, olast_d;
  logic              err_q, err_d;

  logic [DIM_W-1:0]  ra, ca, rb, cb;
  logic [15:0]       pa, pb, pr;
  logic              cfg_ok;
  logic              in_rdy;
  logic              in_hs;
  logic [IDX_W-1:0]  idx_nxt;

  always_comb begin
    ra = cfg_dim(bus.cmd_config, CFG_RA_LSB);
    ca = cfg_dim(bus.cmd_config, CFG_CA_LSB);
    rb = cfg_dim(bus.cmd_config, CFG_RB_LSB);
    cb = cfg_dim(bus.cmd_config, CFG_CB_LSB);
    pa = prod_words(ra, ca);
    pb = prod_words(rb, cb);
    pr = prod_words(ra, cb);
    cfg_ok = (ra != '0) && (ca != '0)
          && (rb != '0) && (cb != '0)
          && (ca == rb)
          && (pa <= 16'(MAX_WORDS))
          && (pb <= 16'(MAX_WORDS))
          && (pr <= 16'(MAX_WORDS));
  end

  assign in_rdy  = (state_q == S_LOAD_A)
                || (state_q == S_LOAD_B);
  assign in_hs   = in_rdy && bus.in_valid;
  assign idx_nxt = idx_q + IDX_W'(1);

  // Writes launch at the closing edge of the state that names them,
  // so the bus shows each write during the following cycle. Reads are
  // launched on entry to RD_ADDR so data is back by the end of RD_DATA.
  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    na_d     = na_q;
    nb_d     = nb_q;
    nr_d     = nr_q;
    idx_d    = idx_q;
    we_d     = 1'b0;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    odata_d  = odata_q;
    ovalid_d = ovalid_q;
    olast_d  = olast_q;
    err_d    = 1'b0;
`ifdef MM_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          if (cfg_ok) begin
            state_d = S_CLR;
            cfg_d   = bus.cmd_config;
            na_d    = pa[IDX_W-1:0];
            nb_d    = pb[IDX_W-1:0];
            nr_d    = pr[IDX_W-1:0];
            idx_d   = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_CLR: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(STATUS_ADDR);
        wdata_d = '0;
        state_d = S_CFG;
      end
      S_CFG: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(CONFIG_ADDR);
        wdata_d = DATA_W'(cfg_q);
        state_d = S_LOAD_A;
      end
      S_LOAD_A: begin
        if (in_hs) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(A_BASE)
                  + ADDR_W'(idx_q);
          wdata_d = bus.in_data;
          if (idx_q == na_q - IDX_W'(1)) begin
            idx_d   = '0;
            state_d = S_LOAD_B;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      S_LOAD_B: begin
        if (in_hs) begin
          we_d    = 1'b1;
          addr_d  = ADDR_W'(B_BASE)
                  + ADDR_W'(idx_q);
          wdata_d = bus.in_data;
          if (idx_q == nb_q - IDX_W'(1)) begin
            idx_d   = '0;
            state_d = S_START;
          end else begin
            idx_d = idx_nxt;
          end
        end
      end
      S_START: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(STATUS_ADDR);
        wdata_d = DATA_W'(START_BIT);
        state_d = S_WAIT;
`ifdef MM_TIMEOUT_EN
        cnt_d   = '0;
`endif
      end
      S_WAIT: begin
        if (bus.result_ready) begin
          addr_d  = ADDR_W'(R_BASE)
                  + ADDR_W'(idx_q);
          state_d = S_RD_ADDR;
        end
`ifdef MM_TIMEOUT_EN
        else if (cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
          err_d   = 1'b1;
          state_d = S_FIN;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
`endif
      end
      S_RD_ADDR: begin
        state_d = S_RD_DATA;
      end
      S_RD_DATA: begin
        odata_d  = bus.memory_data_out;
        ovalid_d = 1'b1;
        olast_d  = (idx_q == nr_q - IDX_W'(1));
        state_d  = S_OUT;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          ovalid_d = 1'b0;
          olast_d  = 1'b0;
          if (olast_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_nxt;
            addr_d  = ADDR_W'(R_BASE)
                    + ADDR_W'(idx_nxt);
            state_d = S_RD_ADDR;
          end
        end
      end
      S_FIN: begin
        we_d    = 1'b1;
        addr_d  = ADDR_W'(STATUS_ADDR);
        wdata_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cfg_q    <= '0;
      na_q     <= '0;
      nb_q     <= '0;
      nr_q     <= '0;
      idx_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      odata_q  <= '0;
      ovalid_q <= 1'b0;
      olast_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef MM_TIMEOUT_EN
      cnt_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      na_q     <= na_d;
      nb_q     <= nb_d;
      nr_q     <= nr_d;
      idx_q    <= idx_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      odata_q  <= odata_d;
      ovalid_q <= ovalid_d;
      olast_q  <= olast_d;
      err_q    <= err_d;
`ifdef MM_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign bus.cmd_ready      = (state_q == S_IDLE);
  assign bus.busy           = (state_q != S_IDLE);
  assign bus.in_ready       = in_rdy;
  assign bus.write_enable   = we_q;
  assign bus.memory_address = addr_q;
  assign bus.memory_data_in = wdata_q;
  assign bus.out_data       = odata_q;
  assign bus.out_valid      = ovalid_q;
  assign bus.out_last       = olast_q;
  assign bus.error          = err_q;

endmodule
